// File: rtl/mux_nx1_rr.sv
// N-to-1 registered mux with valid/ready on every channel; fixed (sel) or round-robin selection.
// Optional per-channel saturating grant counters: define MUX_NX1_GRANT_CNT_EN.
module mux_nx1_rr #(
  parameter int unsigned P = 7,
  parameter int unsigned N = 4,
  parameter int unsigned S = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*(P+1)-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  input  logic [S-1:0]     sel,
  output logic [P:0]       out_data,
  output logic [S-1:0]     out_chan,
  output logic             out_valid,
`ifdef MUX_NX1_GRANT_CNT_EN
  output logic [N*16-1:0]  grant_cnt,
`endif
  input  logic             out_ready
);

  logic [S-1:0] ptr_q;
  logic [N-1:0] gnt;
  logic         any_gnt;
  logic [S-1:0] gnt_idx;
  logic [P:0]   gnt_data;
  logic         ld;
  logic         found;
  int unsigned  j;

  assign ld = !out_valid | out_ready;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    j     = 0;
    if (!mode) begin
      // An out-of-range sel matches no channel, leaving gnt at zero.
      for (int i = 0; i < N; i++) begin
        gnt[i] = in_valid[i] && (sel == S'(i));
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        j = int'(ptr_q) + k;
        if (j >= N) j = j - N;
        if (!found && in_valid[j]) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        gnt_idx  = S'(i);
        gnt_data = in_data[i*(P+1) +: (P+1)];
      end
    end
  end

  assign any_gnt  = |gnt;
  assign in_ready = {N{ld}} & gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr_q     <= '0;
    end else if (ld) begin
      if (any_gnt) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_chan  <= gnt_idx;
        ptr_q     <= (gnt_idx == S'(N - 1)) ? '0 : gnt_idx + S'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_NX1_GRANT_CNT_EN
  logic [N*16-1:0] cnt_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        cnt_q[i*16 +: 16] <= '0;
      end else if (in_valid[i] && in_ready[i] && cnt_q[i*16 +: 16] != 16'hFFFF) begin
        cnt_q[i*16 +: 16] <= cnt_q[i*16 +: 16] + 16'd1;
      end
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr (N=4, P=7): reset, round-robin, fixed mode, backpressure.
module tb_mux_nx1_rr;

  localparam int unsigned P = 7;
  localparam int unsigned N = 4;
  localparam int unsigned S = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*(P+1)-1:0] in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             mode;
  logic [S-1:0]     sel;
  logic [P:0]       out_data;
  logic [S-1:0]     out_chan;
  logic             out_valid;
  logic             out_ready;
`ifdef MUX_NX1_GRANT_CNT_EN
  logic [N*16-1:0]  grant_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  mux_nx1_rr #(.P(P), .N(N), .S(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
`ifdef MUX_NX1_GRANT_CNT_EN
    .grant_cnt (grant_cnt),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input int chan);
    logic [7:0] exp_data [4];
    exp_data[0] = 8'h11;
    exp_data[1] = 8'h22;
    exp_data[2] = 8'h33;
    exp_data[3] = 8'h44;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_chan"}, 32'(out_chan), 32'(chan));
    check({tag, "_data"}, 32'(out_data), 32'(exp_data[chan]));
  endtask

  initial begin
    int rr_all [8];
    int rr_alt [4];
    rr_all = '{0, 1, 2, 3, 0, 1, 2, 3};
    rr_alt = '{1, 3, 1, 3};

    rst_n     = 1'b0;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid  = 4'b1111;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;
    #1;
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_chan", 32'(out_chan), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'b0001);

    // Round-robin with all channels valid.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_beat($sformatf("rr_all%0d", i), rr_all[i]);
    end

    // Only channels 1 and 3 valid; pointer is back at 0.
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check_beat($sformatf("rr_alt%0d", i), rr_alt[i]);
    end

    // Backpressure: ptr=0, stream two beats, then stall three cycles.
    in_valid = 4'b1111;
    step();
    check_beat("bp_pre0", 0);
    step();
    check_beat("bp_pre1", 1);
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'b0000);
      step();
      check_beat($sformatf("bp_hold%0d", i), 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'b0100);
    step();
    check_beat("bp_next0", 2);
    step();
    check_beat("bp_next1", 3);

    // Fixed mode, sel=2.
    mode = 1'b0;
    sel  = 2'd2;
    #1;
    check("fix_in_ready0", 32'(in_ready), 32'b0100);
    step();
    check_beat("fix_beat0", 2);
    check("fix_in_ready1", 32'(in_ready), 32'b0100);
    step();
    check_beat("fix_beat1", 2);
    sel      = 2'd3;
    in_valid = 4'b0111;
    #1;
    check("fix_sel3_in_ready", 32'(in_ready), 32'b0000);
    step();
    check("fix_sel3_valid", 32'(out_valid), 32'd0);
    check("fix_sel3_data_hold", 32'(out_data), 32'h33);

    // Reset mid-stream with a held beat. ptr is 3 after the fixed-mode grants.
    mode     = 1'b1;
    in_valid = 4'b1111;
    step();
    check_beat("mid_pre0", 3);
    step();
    check_beat("mid_pre1", 0);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_chan", 32'(out_chan), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'h00);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mid_ptr_in_ready", 32'(in_ready), 32'b0001);
    step();
    check_beat("mid_post", 0);

`ifdef MUX_NX1_GRANT_CNT_EN
    rst_n = 1'b0;
    step();
    check("cnt_rst", 32'(grant_cnt[31:0]), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("cnt_ch0", 32'(grant_cnt[15:0]), 32'd3);
    check("cnt_ch1", 32'(grant_cnt[31:16]), 32'd3);
    check("cnt_ch2", 32'(grant_cnt[47:32]), 32'd2);
    check("cnt_ch3", 32'(grant_cnt[63:48]), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-input, one-output registered multiplexer with a valid/ready handshake on every channel. Selection is either fixed by a select input, as in the 2-to-1 mux, or round-robin among the channels that are presenting data. It sits between several producers, such as ALU result paths and load paths, and a single shared consumer such as the register-file write port. It provides one registered output stage, so the consumer sees a clean, flopped bus.

## Interface
Parameters:
- `P`, default 7: data MSB index; data width is P+1.
- `N`, default 4: number of input channels, N ≥ 2.
- `S`, default 2: select width, equal to ceil(log2(N)).

Ports:
- `clk`  in  1  the only clock; rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_data`  in  N*(P+1)  packed channel data; channel i occupies bits [i*(P+1)+P : i*(P+1)].
- `in_valid`  in  N  per-channel data-present flag.
- `in_ready`  out  N  per-channel accept flag.
- `mode`  in  1  selection mode: 0 = fixed (use `sel`), 1 = round-robin.
- `sel`  in  S  channel to use in fixed mode.
- `out_data`  out  P+1  registered output data.
- `out_chan`  out  S  index of the channel that produced `out_data`.
- `out_valid`  out  1  output register holds data.
- `out_ready`  in  1  consumer accepts data.

## Operation
- Load enable: `ld = !out_valid | out_ready`.
- Grant is a one-hot combinational signal, `gnt[N-1:0]`.
- Fixed mode (`mode`=0):
  - `gnt[sel] = in_valid[sel]`; all other bits are 0.
  - If `sel` ≥ N, `gnt` = 0.
- Round-robin mode (`mode`=1):
  - Search for a valid channel starting at pointer `ptr` and wrapping: ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - The first valid channel found is granted.
- `in_ready[i] = ld & gnt[i]`.
- A transfer on channel i occurs when `in_valid[i] & in_ready[i]`. On the next edge:
  - `out_data` gets channel i's data.
  - `out_chan` gets i.
  - `out_valid` gets 1.
  - `ptr` gets (i+1) mod N. `ptr` is updated in both modes.
- If `ld` = 1 and no channel is granted, `out_valid` gets 0. `out_data` and `out_chan` hold their values.
- If `ld` = 0, all output registers hold and every `in_ready` bit is 0.
- Consumer-side handshake:
  - `out_data`, `out_chan` and `out_valid` are stable while `out_valid & !out_ready`.
  - An output beat is consumed on a cycle where `out_valid & out_ready`.
- Producer-side handshake:
  - `in_valid` must not depend combinationally on `in_ready`.
  - Once asserted, `in_valid` holds with stable data until the transfer occurs.
- Changes to `mode` or `sel` take effect in the same cycle, because grant is combinational. Any already-registered output beat is unaffected.
- Reset, when `rst_n` = 0 at an edge:
  - `out_valid` = 0, `out_data` = 0, `out_chan` = 0, `ptr` = 0.
  - Any registered beat is dropped.
  - Reset overrides a simultaneous transfer.
- `in_ready` is combinational. While `out_valid` = 0 after reset it still follows `gnt`; producers must treat the reset cycle as no-transfer.

## Timing
- Latency: 1 cycle from the input transfer edge to `out_valid`.
- Throughput: 1 beat per cycle while `out_ready` stays high.
- Combinational paths:
  - `in_valid`, `mode`, `sel` → `in_ready`.
  - `out_ready` → `in_ready`.
  - There is no combinational path from any input to the `out_*` outputs.
- Round-robin fairness: with all N channels continuously valid and `out_ready` = 1, each channel is granted exactly once every N cycles.
- Wrap-around: a grant to channel N-1 sets `ptr` to 0.

## Configuration
- `MUX_NX1_GRANT_CNT_EN` defined: adds output port `grant_cnt`, width N*16.
  - It holds one 16-bit counter per channel, channel i at bits [i*16+15 : i*16].
  - Counter i increments on each transfer from channel i.
  - Counters saturate at 16'hFFFF.
  - All counters reset to 0.
- Macro undefined: the port and counters are absent; all other behaviour is identical.

## Test plan
All scenarios use N=4, P=7.
- Reset: hold `rst_n`=0 for 2 cycles with all `in_valid`=4'b1111 → `out_valid`=0, `out_data`=8'h00, `out_chan`=0. After release, the first beat comes from channel 0.
- Fixed mode:
  - Setup: `mode`=0, `sel`=2, `in_valid`=4'b1111, data {8'h44, 8'h33, 8'h22, 8'h11}, `out_ready`=1.
  - Response: `in_ready`=4'b0100 every cycle; `out_data`=8'h33 and `out_chan`=2 one cycle later.
  - Then set `sel`=3 while `in_valid[3]`=0 → `out_valid` drops to 0 on the next edge.
- Round-robin, all channels valid:
  - Setup: `mode`=1, `in_valid`=4'b1111, `out_ready`=1.
  - Response: `out_chan` sequence 0,1,2,3,0,1 on consecutive cycles.
  - With `in_valid`=4'b1010, the sequence is 1,3,1,3.
- Backpressure:
  - Setup: round-robin streaming; drop `out_ready` for 3 cycles.
  - Response: `in_ready`=4'b0000 and `out_data`/`out_chan` hold for all 3 cycles.
  - On release, the held beat completes, then the next channel in rotation follows with no beat lost or duplicated.
- Reset mid-stream: assert `rst_n`=0 while `out_valid`=1 and `out_ready`=0 → the next edge gives `out_valid`=0 and `ptr`=0, and the held beat is discarded.
- Grant counters (`MUX_NX1_GRANT_CNT_EN` defined):
  - 10 round-robin cycles with all channels valid → counts {2, 2, 3, 3} for channels {3, 2, 1, 0}.
  - A counter preloaded near saturation stays at 16'hFFFF after further grants.
